dmem_responder: RTL and testbench

- Responder (slave) end of the core's data-memory request interface. It accepts one load/store request at a time from the memory stage.
- It applies a programmable number of wait states and services the access against an internal word-addressed byte-strobed RAM.
- It returns a response over a valid/ready handshake with an error flag, and asserts busy so the hazard logic can stall the pipeline while a transaction is outstanding.

---
 rtl/dmem_responder_pkg.sv | 18 +
 rtl/dmem_byte_ram.sv | 36 +++
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_responder_pkg : shared FSM encoding and constants for the responder
// Revision: 1.0
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0]  WSTRB_FULL      = 4'b1111;
    localparam logic [31:0] ADDR_ALIGN_MASK = 32'h0000_0003;

endpackage
`default_nettype wire

// File: rtl/dmem_byte_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_byte_ram : single-port word RAM, per-byte write enables, registered read
// Revision: 1.0
// ---------------------------------------------------------------------------
module dmem_byte_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    // One byte-wide array per lane; the read register returns pre-write data.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] q;

        always_ff @(posedge clk) begin
            if (en) begin
                if (we[i]) begin
                    mem[addr] <= wdata[8*i +: 8];
                end
                q <= mem[addr];
            end
        end

        assign rdata[8*i +: 8] = q;
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_responder : data-memory responder with wait states, fault check, busy
// Revision: 1.0
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wstrb;
    logic        rsp_is_load;
    logic        err_q;

    logic        accept;
    logic        commit;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wstrb;
    logic [32:0] offset;
    logic        fault;
    logic [3:0]  ram_we;
    logic [31:0] ram_q;

    assign accept = req_valid && (state == ST_IDLE);

    // With zero wait states the commit happens on the acceptance edge itself,
    // so the access fields come straight from the request port in IDLE.
    always_comb begin
        acc_we    = lat_we;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        acc_wstrb = lat_wstrb;
        if (state == ST_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_wstrb = req_wstrb;
        end
        commit = (accept && (WAIT_CYCLES == 0)) ||
                 ((state == ST_WAIT) && (wait_cnt == 4'd1));
    end

    // Bit 32 of the widened difference flags an address below the window.
    assign offset = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
    assign fault  = (|(offset[31:0] & ADDR_ALIGN_MASK)) || offset[32] ||
                    (offset[31:AW+2] != '0);
    assign ram_we = (commit && acc_we && !fault) ? acc_wstrb : 4'b0000;

    dmem_byte_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .en    (commit),
        .we    (ram_we),
        .addr  (offset[AW+1:2]),
        .wdata (acc_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= 4'd0;
            lat_we      <= 1'b0;
            lat_addr    <= 32'd0;
            lat_wdata   <= 32'd0;
            lat_wstrb   <= 4'd0;
            rsp_is_load <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_wstrb <= req_wstrb;
                        wait_cnt  <= 4'(WAIT_CYCLES);
                        state     <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (commit) begin
                err_q       <= fault;
                rsp_is_load <= !acc_we && !fault;
            end
        end
    end

    // The RAM read register only moves on commit, so the gated data holds
    // steady for as long as the requester stalls the response.
    assign rsp_rdata = rsp_is_load ? ram_q : 32'd0;
    assign rsp_err   = err_q;
    assign rsp_valid = (state == ST_RESP);
    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_responder : scoreboard bench for dmem_responder (two configurations)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int W_A = 2;
    localparam int W_B = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Configuration A: 256 words at 0, two wait states
    logic        rst_a, rqv_a, we_a, rsr_a;
    logic [31:0] addr_a, wdata_a;
    logic [3:0]  wstrb_a;
    logic        rdy_a, rv_a, er_a, busy_a;
    logic [31:0] rd_a;

    // Configuration B: 16 words at 0x1000, zero wait states
    logic        rst_b, rqv_b, we_b, rsr_b;
    logic [31:0] addr_b, wdata_b;
    logic [3:0]  wstrb_b;
    logic        rdy_b, rv_b, er_b, busy_b;
    logic [31:0] rd_b;

    dmem_responder #(
        .DEPTH_WORDS (256), .WAIT_CYCLES (W_A), .BASE_ADDR (32'h0000_0000)
    ) dut_a (
        .clk (clk), .rst (rst_a), .req_valid (rqv_a), .req_ready (rdy_a),
        .req_we (we_a), .req_addr (addr_a), .req_wdata (wdata_a), .req_wstrb (wstrb_a),
        .rsp_valid (rv_a), .rsp_ready (rsr_a), .rsp_rdata (rd_a), .rsp_err (er_a),
        .busy (busy_a)
    );

    dmem_responder #(
        .DEPTH_WORDS (16), .WAIT_CYCLES (W_B), .BASE_ADDR (32'h0000_1000)
    ) dut_b (
        .clk (clk), .rst (rst_b), .req_valid (rqv_b), .req_ready (rdy_b),
        .req_we (we_b), .req_addr (addr_b), .req_wdata (wdata_b), .req_wstrb (wstrb_b),
        .rsp_valid (rv_b), .rsp_ready (rsr_b), .rsp_rdata (rd_b), .rsp_err (er_b),
        .busy (busy_b)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        time         t_acc;
        string       name;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    bit   seen_a = 0;
    bit   seen_b = 0;
    time  last_b = 0;
    bit   have_last_b = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: latency on first sight of a response, data/err every valid cycle
    always @(negedge clk) begin
        if (!rst_a) seen_a = 0;
        else if (rv_a) begin
            if (q_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_rsp: got rsp_valid=1 expected no response");
            end else begin
                if (!seen_a) begin
                    chk({q_a[0].name, "_latency"}, 32'($time - q_a[0].t_acc), 32'(W_A * 10 + 5));
                    seen_a = 1;
                end
                chk({q_a[0].name, "_rdata"}, rd_a, q_a[0].rdata);
                chk({q_a[0].name, "_err"}, {31'd0, er_a}, {31'd0, q_a[0].err});
                if (rsr_a) begin
                    void'(q_a.pop_front());
                    seen_a = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b) seen_b = 0;
        else if (rv_b) begin
            if (q_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_rsp: got rsp_valid=1 expected no response");
            end else begin
                if (!seen_b) begin
                    chk({q_b[0].name, "_latency"}, 32'($time - q_b[0].t_acc), 32'(W_B * 10 + 5));
                    seen_b = 1;
                end
                chk({q_b[0].name, "_rdata"}, rd_b, q_b[0].rdata);
                chk({q_b[0].name, "_err"}, {31'd0, er_b}, {31'd0, q_b[0].err});
                if (rsr_b) begin
                    void'(q_b.pop_front());
                    seen_b = 0;
                end
            end
        end
    end

    task automatic req_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input bit push,
                         input logic [31:0] exp_rdata, input logic exp_err, input string name);
        bit ok = 0;
        @(posedge clk); #1;
        rqv_a = 1; we_a = we; addr_a = addr; wdata_a = wdata; wstrb_a = wstrb;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdy_a) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_accept: req_ready got 0 expected 1", name);
            rqv_a = 0;
            return;
        end
        @(posedge clk);
        if (push) q_a.push_back('{exp_rdata, exp_err, $time, name});
        #1 rqv_a = 0;
    endtask

    // Leaves req_valid high so successive calls form a back-to-back stream.
    task automatic req_b(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                         input logic exp_err, input string name);
        bit ok = 0;
        rqv_b = 1; we_b = we; addr_b = addr; wdata_b = wdata; wstrb_b = wstrb;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdy_b) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_accept: req_ready got 0 expected 1", name);
            return;
        end
        @(posedge clk);
        q_b.push_back('{exp_rdata, exp_err, $time, name});
        if (have_last_b) chk({name, "_interval"}, 32'($time - last_b), 32'd20);
        last_b = $time;
        have_last_b = 1;
        #1;
    endtask

    task automatic drain(input bit sel, input string name);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sel == 0 && q_a.size() == 0 && !busy_a) begin ok = 1; break; end
            if (sel == 1 && q_b.size() == 0 && !busy_b) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_drain: got outstanding responses expected none", name);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got_valid;
        rst_a = 0; rqv_a = 0; we_a = 0; addr_a = 0; wdata_a = 0; wstrb_a = 0; rsr_a = 1;
        rst_b = 0; rqv_b = 0; we_b = 0; addr_b = 0; wdata_b = 0; wstrb_b = 0; rsr_b = 1;
        #2;
        chk("rst_rsp_valid", {31'd0, rv_a}, 32'd0);
        chk("rst_rsp_rdata", rd_a, 32'd0);
        chk("rst_rsp_err", {31'd0, er_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        repeat (2) @(negedge clk);
        rst_a = 1; rst_b = 1;
        #1 chk("rst_req_ready", {31'd0, rdy_a}, 32'd1);

        // Configuration A directed vectors
        req_a(1, 32'h20,  32'hCAFE_F00D, WSTRB_FULL, 1, 32'h0, 0, "st20");
        req_a(1, 32'h10,  32'hDEAD_BEEF, WSTRB_FULL, 1, 32'h0, 0, "st10");
        req_a(0, 32'h10,  32'h0,         4'b0000,    1, 32'hDEAD_BEEF, 0, "ld10");
        req_a(1, 32'h10,  32'h0000_AA00, 4'b0010,    1, 32'h0, 0, "st10_part");
        req_a(0, 32'h10,  32'h0,         WSTRB_FULL, 1, 32'hDEAD_AAEF, 0, "ld10_part");
        req_a(0, 32'h13,  32'h0,         4'b0000,    1, 32'h0, 1, "ld13_misal");
        req_a(1, 32'h400, 32'hFFFF_FFFF, WSTRB_FULL, 1, 32'h0, 1, "st400_oor");
        req_a(1, 32'h3FC, 32'h0BAD_C0DE, WSTRB_FULL, 1, 32'h0, 0, "st3fc");
        req_a(0, 32'h3FC, 32'h0,         4'b0000,    1, 32'h0BAD_C0DE, 0, "ld3fc");
        req_a(1, 32'h10,  32'hFFFF_FFFF, 4'b0000,    1, 32'h0, 0, "st10_nostrb");
        req_a(0, 32'h10,  32'h0,         4'b0000,    1, 32'hDEAD_AAEF, 0, "ld10_after_faults");

        // Backpressure with a competing request that must be ignored
        drain(0, "pre_bp");
        rsr_a = 0;
        req_a(0, 32'h10, 32'h0, 4'b0000, 1, 32'hDEAD_AAEF, 0, "ld10_bp");
        got_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rv_a) begin got_valid = 1; break; end
        end
        chk("bp_rsp_valid_seen", {31'd0, got_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            rqv_a = 1; we_a = 1; addr_a = 32'h10; wdata_a = 32'h1111_1111; wstrb_a = WSTRB_FULL;
            @(negedge clk);
            chk("bp_req_ready", {31'd0, rdy_a}, 32'd0);
            chk("bp_busy", {31'd0, busy_a}, 32'd1);
        end
        @(posedge clk); #1;
        rsr_a = 1; rqv_a = 0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_valid", {31'd0, rv_a}, 32'd0);
        chk("bp_release_busy", {31'd0, busy_a}, 32'd0);
        req_a(0, 32'h10, 32'h0, 4'b0000, 1, 32'hDEAD_AAEF, 0, "ld10_after_bp");

        // Reset during the first wait cycle drops the store
        drain(0, "pre_rst");
        req_a(1, 32'h20, 32'h1234_5678, WSTRB_FULL, 0, 32'h0, 0, "st20_dropped");
        chk("wait_busy", {31'd0, busy_a}, 32'd1);
        rst_a = 0;
        #1;
        chk("midrst_rsp_valid", {31'd0, rv_a}, 32'd0);
        chk("midrst_busy", {31'd0, busy_a}, 32'd0);
        chk("midrst_rsp_rdata", rd_a, 32'd0);
        chk("midrst_rsp_err", {31'd0, er_a}, 32'd0);
        @(negedge clk);
        rst_a = 1;
        req_a(0, 32'h20, 32'h0, 4'b0000, 1, 32'hCAFE_F00D, 0, "ld20_after_rst");
        drain(0, "end_a");

        // Configuration B: back-to-back stream, window 0x1000..0x103F
        @(posedge clk); #1;
        req_b(1, 32'h1000, 32'hA5A5_A5A5, WSTRB_FULL, 32'h0, 0, "b_st1000");
        req_b(1, 32'h103C, 32'h5A5A_5A5A, WSTRB_FULL, 32'h0, 0, "b_st103c");
        req_b(0, 32'h1000, 32'h0, 4'b0000, 32'hA5A5_A5A5, 0, "b_ld1000");
        req_b(0, 32'h103C, 32'h0, 4'b0000, 32'h5A5A_5A5A, 0, "b_ld103c");
        req_b(0, 32'h0FFC, 32'h0, 4'b0000, 32'h0, 1, "b_ld_below");
        req_b(1, 32'h1040, 32'hFFFF_FFFF, WSTRB_FULL, 32'h0, 1, "b_st_above");
        req_b(0, 32'h1002, 32'h0, 4'b0000, 32'h0, 1, "b_ld_misal");
        req_b(1, 32'h1000, 32'h0000_00C3, 4'b0001, 32'h0, 0, "b_st_lane0");
        req_b(0, 32'h1000, 32'h0, 4'b0000, 32'hA5A5_A5C3, 0, "b_ld_lane0");
        rqv_b = 0;
        drain(1, "end_b");

        chk("queue_a_empty", q_a.size(), 32'd0);
        chk("queue_b_empty", q_b.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
